// File: rtl/stage_if_pkg.sv
// rtl/stage_if_pkg.sv - shared constants and types for the instruction-fetch stage
// Contents:
//   XLEN             instruction / PC width
//   IF_NOP_INST      default bubble word (addi x0,x0,0)
//   IF_RESET_PC      default first fetch address
//   DISCARD_W        width of the stale-response discard counter
//   fq_entry_t       fetch-queue entry {pc, inst}
package stage_if_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] IF_NOP_INST = 32'h0000_0013;
  localparam logic [XLEN-1:0] IF_RESET_PC = 32'h0000_0000;

  // Repeated redirects can stack stale responses beyond one queue's worth.
  localparam int DISCARD_W = 8;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/if_fifo.sv
// rtl/if_fifo.sv - synchronous FIFO used for the fetch queue and the pending-PC list
// Parameters: DEPTH (power of 2, >=2), WIDTH
// Ports:
//   clk, rst        clock, async active-high reset
//   push, din       write din at the clock edge
//   pop             advance head at the clock edge
//   flush           empty the FIFO (wins over push/pop)
//   dout            current head word (valid when count != 0)
//   count           number of stored words
module if_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage needs no reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/stage_if.sv
// rtl/stage_if.sv - instruction-fetch stage feeding decode over a req/gnt/rvalid memory port
// Optional feature macro: STAGE_IF_PERF_CNT_EN (adds perf_fetch_cnt/perf_bubble_cnt/perf_squash_cnt)
// Ports:
//   clk, rst                       clock, async active-high reset
//   ctrl_stall                     decode stalled; hold head entry
//   br_redirect, br_target         one-cycle redirect pulse and new PC
//   imem_req, imem_addr            fetch request and word address
//   imem_gnt                       request accepted
//   imem_rvalid, imem_rdata        in-order response
//   id_inst, id_pc, id_valid       instruction to decode
module stage_if
  import stage_if_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = IF_RESET_PC,
  parameter int              FQ_DEPTH = 2,
  parameter logic [XLEN-1:0] NOP_INST = IF_NOP_INST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ctrl_stall,
  input  logic            br_redirect,
  input  logic [XLEN-1:0] br_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] id_inst,
  output logic [XLEN-1:0] id_pc,
  output logic            id_valid
`ifdef STAGE_IF_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch_cnt,
  output logic [31:0]     perf_bubble_cnt,
  output logic [31:0]     perf_squash_cnt
`endif
);

  localparam int CW = $clog2(FQ_DEPTH) + 1;
  localparam logic [CW:0] FQ_DEPTH_C = (CW+1)'(FQ_DEPTH);

  logic [XLEN-1:0]      pc;
  logic [XLEN-1:0]      pend_pc;
  logic [CW-1:0]        pend_cnt;
  logic [CW-1:0]        fq_cnt;
  logic [CW:0]          inflight;
  logic [DISCARD_W-1:0] discard_cnt;
  fq_entry_t            fq_head;
  fq_entry_t            fq_din;
  logic                 grant;
  logic                 rsp_drop;
  logic                 rsp_keep;
  logic                 fq_pop;
  logic                 unused_target_lsbs;

  assign unused_target_lsbs = ^br_target[1:0];

  // Credit covers words still in memory plus words already queued, so a
  // response can never find the fetch queue full.
  assign inflight  = {1'b0, pend_cnt} + {1'b0, fq_cnt};
  assign imem_req  = !rst && !br_redirect && (inflight < FQ_DEPTH_C);
  assign imem_addr = pc;
  assign grant     = imem_req && imem_gnt;

  // A response in the redirect cycle belongs to the old path as well.
  assign rsp_drop = imem_rvalid && (br_redirect || (discard_cnt != '0));
  assign rsp_keep = imem_rvalid && !rsp_drop;

  assign id_valid = (fq_cnt != '0);
  assign fq_pop   = id_valid && !ctrl_stall && !br_redirect;
  assign fq_din   = '{pc: pend_pc, inst: imem_rdata};

  if_fifo #(.DEPTH(FQ_DEPTH), .WIDTH(XLEN)) u_pend (
    .clk   (clk),
    .rst   (rst),
    .push  (grant),
    .pop   (rsp_keep),
    .flush (br_redirect),
    .din   (pc),
    .dout  (pend_pc),
    .count (pend_cnt)
  );

  if_fifo #(.DEPTH(FQ_DEPTH), .WIDTH($bits(fq_entry_t))) u_fq (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_keep),
    .pop   (fq_pop),
    .flush (br_redirect),
    .din   (fq_din),
    .dout  (fq_head),
    .count (fq_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              pc <= RESET_PC;
    else if (br_redirect) pc <= {br_target[XLEN-1:2], 2'b00};
    else if (grant)       pc <= pc + 32'd4;
  end

  // Every request still pending at a redirect becomes a response to drop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      discard_cnt <= '0;
    else if (br_redirect)
      discard_cnt <= discard_cnt + DISCARD_W'(pend_cnt) - DISCARD_W'(imem_rvalid);
    else if (imem_rvalid && (discard_cnt != '0))
      discard_cnt <= discard_cnt - 1'b1;
  end

  assign id_inst = id_valid ? fq_head.inst : NOP_INST;
  assign id_pc   = id_valid ? fq_head.pc   : '0;

`ifdef STAGE_IF_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt  <= '0;
      perf_bubble_cnt <= '0;
      perf_squash_cnt <= '0;
    end else begin
      if (grant)    perf_fetch_cnt  <= perf_fetch_cnt + 32'd1;
      if (!id_valid) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      if (rsp_drop) perf_squash_cnt <= perf_squash_cnt + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  a_rvalid_expected: assert property (@(posedge clk) disable iff (rst)
    imem_rvalid |-> ((pend_cnt != '0) || (discard_cnt != '0)));
  a_credit: assert property (@(posedge clk) disable iff (rst)
    inflight <= FQ_DEPTH_C);
  a_fq_overflow: assert property (@(posedge clk) disable iff (rst)
    rsp_keep |-> (({1'b0, fq_cnt} < FQ_DEPTH_C) || fq_pop));
`endif

endmodule

// File: tb/tb_stage_if.sv
// tb/tb_stage_if.sv - self-checking bench for stage_if with memory model and PC scoreboard
module tb_stage_if;

  localparam int          FQD = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ctrl_stall = 1'b0;
  logic        br_redirect = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic        id_valid;
`ifdef STAGE_IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;
  logic [31:0] perf_squash_cnt;
`endif

  int tests = 0;
  int fails = 0;

  stage_if #(.RESET_PC(32'h0), .FQ_DEPTH(FQD), .NOP_INST(NOP)) dut (
    .clk         (clk),
    .rst         (rst),
    .ctrl_stall  (ctrl_stall),
    .br_redirect (br_redirect),
    .br_target   (br_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_inst     (id_inst),
    .id_pc       (id_pc),
    .id_valid    (id_valid)
`ifdef STAGE_IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_bubble_cnt (perf_bubble_cnt),
    .perf_squash_cnt (perf_squash_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(logic [31:0] a);
    return (a * 32'd3) ^ 32'h5A00_0001;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: granted addresses answered in order after 'lat' cycles.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mem_q[$];
  logic [31:0] exp_q[$];
  int          cyc = 0;
  int          lat = 1;
  int          gnt_mode = 1;   // 0 never, 1 always, 2 random
  int          n_consumed = 0;
  int          n_grants = 0;
  logic [31:0] last_grant = 32'h0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        mem_q.delete();
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b0;
      end else begin
        imem_gnt = (gnt_mode == 1) || ((gnt_mode == 2) && ($urandom_range(1, 0) == 1));
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
          imem_rvalid = 1'b1;
          imem_rdata  = inst_of(mem_q[0].addr);
        end else begin
          imem_rvalid = 1'b0;
          imem_rdata  = 32'hDEAD_BEEF;
        end
      end
    end
  end

  // Scoreboard: expected PCs pushed on grant, popped when decode consumes.
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst) begin
      exp_q.delete();
      n_grants = 0;
    end else begin
      if (imem_rvalid && mem_q.size() > 0) mem_q.delete(0);
      if (id_valid && !ctrl_stall && !br_redirect) begin
        n_consumed++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_stale: id_pc %h consumed while no PC expected", id_pc);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", id_pc, e);
          chk("sb_inst", id_inst, inst_of(e));
        end
      end
      if (br_redirect) exp_q.delete();
      if (imem_req && imem_gnt) begin
        exp_q.push_back(imem_addr);
        mem_q.push_back('{imem_addr, cyc + lat});
        last_grant = imem_addr;
        n_grants++;
      end
    end
  end

  task automatic cyc_start();
    @(posedge clk);
    #2;
  endtask

  task automatic run(int n);
    repeat (n) cyc_start();
  endtask

  task automatic wait_valid(string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc_start();
      #1;
      if (id_valid) begin
        ok = 1'b1;
        break;
      end
    end
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: id_valid never rose within 40 cycles", name);
    end
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_req"},   {31'h0, imem_req}, 32'h0);
    chk({tag, "_valid"}, {31'h0, id_valid}, 32'h0);
    chk({tag, "_inst"},  id_inst, NOP);
    chk({tag, "_pc"},    id_pc, 32'h0);
`ifdef STAGE_IF_PERF_CNT_EN
    chk({tag, "_perf_fetch"},  perf_fetch_cnt, 32'h0);
    chk({tag, "_perf_bubble"}, perf_bubble_cnt, 32'h0);
    chk({tag, "_perf_squash"}, perf_squash_cnt, 32'h0);
`endif
  endtask

  typedef struct {
    logic [31:0] target;
    int          latency;
    bit          rnd;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{32'h0000_0103, 1, 1'b0, 32'h0000_0100};
    vecs[1] = '{32'h7FFF_FFFE, 2, 1'b1, 32'h7FFF_FFFC};
    vecs[2] = '{32'hFFFF_FFFC, 1, 1'b0, 32'hFFFF_FFFC};
    vecs[3] = '{32'hFFFF_FFF9, 3, 1'b1, 32'hFFFF_FFF8};

    // Reset state
    repeat (2) @(posedge clk);
    #3;
    chk_reset_outputs("rst");

    // Streaming from reset, grant every cycle, 1-cycle response
    rst = 1'b0;
    cyc_start(); #1;
    chk("t1_addr0", imem_addr, 32'h0);
    chk("t1_req0", {31'h0, imem_req}, 32'h1);
    chk("t1_nv0", {31'h0, id_valid}, 32'h0);
    cyc_start(); #1;
    chk("t1_addr1", imem_addr, 32'h4);
    chk("t1_nv1", {31'h0, id_valid}, 32'h0);
    cyc_start(); #1;
    chk("t1_valid2", {31'h0, id_valid}, 32'h1);
    chk("t1_pc0", id_pc, 32'h0);
    chk("t1_addr2", imem_addr, 32'h8);
    cyc_start(); #1;
    chk("t1_pc4", id_pc, 32'h4);
    cyc_start(); #1;
    chk("t1_pc8", id_pc, 32'h8);

    // Stall with queue filling: head held, requests stop at the credit cap
    ctrl_stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc_start(); #1;
      chk("t2_hold_pc", id_pc, 32'h8);
      chk("t2_hold_inst", id_inst, inst_of(32'h8));
    end
    chk("t2_req_cap", {31'h0, imem_req}, 32'h0);
    ctrl_stall = 1'b0;
    run(10);

    // Redirect with words in flight
    lat = 3;
    run(8);
    cyc_start();
    br_redirect = 1'b1;
    br_target   = 32'h0000_0103;
    #1;
    chk("t3_req_redirect", {31'h0, imem_req}, 32'h0);
    cyc_start();
    br_redirect = 1'b0;
    #1;
    chk("t3_nv_after", {31'h0, id_valid}, 32'h0);
    chk("t3_addr", imem_addr, 32'h0000_0100);
    chk("t3_req", {31'h0, imem_req}, 32'h1);
    wait_valid("t3_wait");
    chk("t3_pc", id_pc, 32'h0000_0100);
    chk("t3_inst", id_inst, inst_of(32'h0000_0100));
    run(6);

    // Redirect coinciding with a response while decode is stalled
    lat = 2;
    run(6);
    begin
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 20; i++) begin
        cyc_start();
        if (imem_rvalid) begin
          hit = 1'b1;
          break;
        end
      end
      tests++;
      if (!hit) begin
        fails++;
        $display("FAIL t4_find_rvalid: no response within 20 cycles");
      end
    end
    ctrl_stall  = 1'b1;
    br_redirect = 1'b1;
    br_target   = 32'h0000_0040;
    cyc_start();
    br_redirect = 1'b0;
    #1;
    chk("t4_flushed", {31'h0, id_valid}, 32'h0);
    ctrl_stall = 1'b0;
    wait_valid("t4_wait");
    chk("t4_pc", id_pc, 32'h0000_0040);
    run(6);

    // Grant withheld: request and address stay put, bubbles downstream
    gnt_mode = 0;
    run(10);
    for (int i = 0; i < 5; i++) begin
      cyc_start(); #1;
      chk("t5_req", {31'h0, imem_req}, 32'h1);
      chk("t5_addr", imem_addr, last_grant + 32'd4);
      chk("t5_nv", {31'h0, id_valid}, 32'h0);
      chk("t5_nop", id_inst, NOP);
      chk("t5_pc0", id_pc, 32'h0);
    end
    gnt_mode = 1;
    wait_valid("t5_wait");
    chk("t5_resume_pc", id_pc, last_grant - 32'd4 * (exp_q.size() - 1));
    run(6);

    // Redirect vector table: alignment, wrap-around and random grant/stall
    foreach (vecs[k]) begin
      lat      = vecs[k].latency;
      gnt_mode = vecs[k].rnd ? 2 : 1;
      cyc_start();
      br_redirect = 1'b1;
      br_target   = vecs[k].target;
      cyc_start();
      br_redirect = 1'b0;
      wait_valid("t6_wait");
      chk("t6_first_pc", id_pc, vecs[k].exp_pc);
      chk("t6_first_inst", id_inst, inst_of(vecs[k].exp_pc));
      for (int i = 0; i < 15; i++) begin
        cyc_start();
        ctrl_stall = vecs[k].rnd ? 1'($urandom_range(1, 0)) : 1'b0;
      end
      ctrl_stall = 1'b0;
      run(4);
    end

    // Reset mid-stream with words in flight
    gnt_mode = 1;
    lat = 2;
    run(5);
    @(posedge clk);
    #3;
    rst = 1'b1;
    imem_rvalid = 1'b0;
    mem_q.delete();
    #1;
    chk_reset_outputs("t7");
    run(2);
    rst = 1'b0;
    cyc_start(); #1;
    chk("t7_addr", imem_addr, 32'h0);
    chk("t7_req", {31'h0, imem_req}, 32'h1);
    wait_valid("t7_wait");
    chk("t7_pc", id_pc, 32'h0);
    run(8);
`ifdef STAGE_IF_PERF_CNT_EN
    #1;
    chk("perf_fetch_total", perf_fetch_cnt, n_grants);
`endif

    tests++;
    if (n_consumed < 50) begin
      fails++;
      $display("FAIL sb_volume: consumed %0d words, need at least 50", n_consumed);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
